// File: rtl/sqrt_sched_pkg.sv
// Shared defaults and helpers for the sqrt request scheduler.
package sqrt_sched_pkg;

    localparam int NREQ_DEFAULT       = 2;
    localparam int TAGW_DEFAULT       = 4;
    // The sqrt unit's owner keeps this equal to its pipeline stage count.
    localparam int SQRT_LAT_DEFAULT   = 5;
    localparam int FIFO_DEPTH_DEFAULT = 8;
    localparam int OPW                = 32;

    function automatic logic [1:0] first_set4(input logic [3:0] v);
        logic [1:0] idx;
        casez (v)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/sqrt_sched_fifo.sv
// First-word-fall-through result FIFO; a write and a read in the same cycle
// are both honoured, including when full.
module sqrt_sched_fifo
    import sqrt_sched_pkg::*;
#(
    parameter int W     = OPW,
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_s, do_wr_s, do_rd_s;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? AW'(0) : p + AW'(1);
    endfunction

    // Pointer/occupancy next state and head presentation.
    always_comb begin
        full_s   = (count_q == CW'(DEPTH));
        empty    = (count_q == CW'(0));
        do_rd_s  = rd_en & ~empty;
        do_wr_s  = wr_en & (~full_s | do_rd_s);
        wr_ptr_d = do_wr_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_rd_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({do_wr_s, do_rd_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        rd_data = mem_q[rd_ptr_q];
    end

    // Storage and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr_s) begin
                mem_q[wr_ptr_q] <= wr_data;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sqrt_sched.sv
// Round-robin scheduler sharing one fixed-latency pipelined sqrt unit between
// NREQ requesters, with credit-protected result buffering.
module sqrt_sched
    import sqrt_sched_pkg::*;
#(
    parameter int NREQ       = NREQ_DEFAULT,
    parameter int TAGW       = TAGW_DEFAULT,
    parameter int SQRT_LAT   = SQRT_LAT_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    localparam int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_x,
    input  logic [NREQ*TAGW-1:0] req_tag,
    output logic [31:0]          sq_x,
    input  logic [31:0]          sq_y,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [31:0]          res_y,
    output logic [IDW-1:0]       res_id,
    output logic [TAGW-1:0]      res_tag
);

    localparam int CNTW = $clog2(FIFO_DEPTH + 1);
    localparam int FW   = 32 + IDW + TAGW;

    logic [IDW-1:0]  rr_q, rr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [31:0]     sq_x_q, sq_x_d;
    logic [NREQ-1:0] rot_s;
    logic [1:0]      first_s;
    logic [IDW-1:0]  gnt_id_s;
    logic            found_s, credit_ok_s, accept_s, pop_s;
    logic [31:0]     opnd_s;
    logic [TAGW-1:0] tag_s;
    logic            fifo_empty_s;
    logic [FW-1:0]   fifo_rd_s;

    logic            trk_v_q   [SQRT_LAT+1];
    logic [IDW-1:0]  trk_id_q  [SQRT_LAT+1];
    logic [TAGW-1:0] trk_tag_q [SQRT_LAT+1];

    // Arbitration, credit accounting and operand selection.
    always_comb begin
        rot_s       = NREQ'({req_valid, req_valid} >> rr_q);
        first_s     = first_set4(4'(rot_s));
        found_s     = |req_valid;
        gnt_id_s    = IDW'((int'(rr_q) + int'(first_s)) % NREQ);
        credit_ok_s = (cnt_q < CNTW'(FIFO_DEPTH));
        accept_s    = found_s & credit_ok_s;
        req_ready   = accept_s ? (NREQ'(1) << gnt_id_s) : NREQ'(0);
        opnd_s      = '0;
        tag_s       = '0;
        for (int i = 0; i < NREQ; i++) begin
            opnd_s = opnd_s | (req_x[32*i +: 32] & {32{req_ready[i]}});
            tag_s  = tag_s | (req_tag[TAGW*i +: TAGW] & {TAGW{req_ready[i]}});
        end
        pop_s = res_valid & res_ready;
        case ({accept_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNTW'(1);
            2'b01:   cnt_d = cnt_q - CNTW'(1);
            default: cnt_d = cnt_q;
        endcase
        rr_d   = accept_s ? IDW'((int'(gnt_id_s) + 1) % NREQ) : rr_q;
        sq_x_d = accept_s ? opnd_s : sq_x_q;
    end

    // Scheduler state plus the {v,id,tag} line that shadows the sqrt pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q   <= '0;
            cnt_q  <= '0;
            sq_x_q <= '0;
            for (int k = 0; k <= SQRT_LAT; k++) begin
                trk_v_q[k]   <= 1'b0;
                trk_id_q[k]  <= '0;
                trk_tag_q[k] <= '0;
            end
        end else begin
            rr_q         <= rr_d;
            cnt_q        <= cnt_d;
            sq_x_q       <= sq_x_d;
            trk_v_q[0]   <= accept_s;
            trk_id_q[0]  <= gnt_id_s;
            trk_tag_q[0] <= tag_s;
            for (int k = 1; k <= SQRT_LAT; k++) begin
                trk_v_q[k]   <= trk_v_q[k-1];
                trk_id_q[k]  <= trk_id_q[k-1];
                trk_tag_q[k] <= trk_tag_q[k-1];
            end
        end
    end

    // Credits guarantee room whenever the last tracking entry is valid.
    sqrt_sched_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (trk_v_q[SQRT_LAT]),
        .wr_data ({sq_y, trk_id_q[SQRT_LAT], trk_tag_q[SQRT_LAT]}),
        .rd_en   (res_ready),
        .rd_data (fifo_rd_s),
        .empty   (fifo_empty_s)
    );

    assign sq_x      = sq_x_q;
    assign res_valid = ~fifo_empty_s;
    assign res_y     = fifo_rd_s[FW-1 -: 32];
    assign res_id    = fifo_rd_s[TAGW +: IDW];
    assign res_tag   = fifo_rd_s[TAGW-1:0];

endmodule

// File: tb/tb_sqrt_sched.sv
// Scoreboard bench for sqrt_sched with a behavioural sqrt stand-in on perfect-square operands.
module tb_sqrt_sched;

    localparam int NREQ  = 2;
    localparam int TAGW  = 4;
    localparam int LAT   = 5;
    localparam int DEPTH = 8;
    localparam int IDW   = 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid, req_ready;
    logic [NREQ*32-1:0]   req_x;
    logic [NREQ*TAGW-1:0] req_tag;
    logic [31:0]          sq_x, sq_y;
    logic                 res_valid, res_ready;
    logic [31:0]          res_y;
    logic [IDW-1:0]       res_id;
    logic [TAGW-1:0]      res_tag;

    always #5 clk = ~clk;

    sqrt_sched #(
        .NREQ(NREQ), .TAGW(TAGW), .SQRT_LAT(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_tag(req_tag),
        .sq_x(sq_x), .sq_y(sq_y),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_y(res_y), .res_id(res_id), .res_tag(res_tag)
    );

    function automatic logic [31:0] itof(input logic [31:0] v);
        int p;
        logic [31:0] m;
        if (v == 32'd0) return 32'd0;
        p = 0;
        for (int k = 0; k < 24; k++) if (v[k]) p = k;
        m = v << (23 - p);
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    function automatic logic [31:0] ftoi(input logic [31:0] b);
        int e;
        logic [31:0] m;
        if (b[30:0] == 31'd0) return 32'd0;
        e = int'(b[30:23]) - 127;
        if (e < 0 || e > 23) return 32'd0;
        m = {8'd0, 1'b1, b[22:0]};
        return m >> (23 - e);
    endfunction

    function automatic logic [31:0] isqrt(input logic [31:0] v);
        logic [31:0] r, t;
        r = 32'd0;
        for (int bt = 11; bt >= 0; bt--) begin
            t = r | (32'd1 << bt);
            if (t * t <= v) r = t;
        end
        return r;
    endfunction

    // Stand-in sqrt unit: LAT edges from sq_x to sq_y.
    logic [31:0] sq_pipe [LAT];
    always @(posedge clk) begin
        sq_pipe[0] <= itof(isqrt(ftoi(sq_x)));
        for (int k = 1; k < LAT; k++) sq_pipe[k] <= sq_pipe[k-1];
    end
    assign sq_y = sq_pipe[LAT-1];

    typedef struct {
        logic [31:0] y;
        int          id;
        int          tag;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          gnt_log[$];
    int          req_n   [NREQ];
    int          req_t   [NREQ];
    int          checks = 0, errors = 0;
    int          cyc = 0, mcnt = 0, mrr = 0;
    int          dut_acc = 0, dut_pops = 0;
    int          g;
    logic [NREQ-1:0] exp_rdy;
    bit          exp_v;
    exp_t        e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor + reference model: arbitration and credits from the rules, results from a queue.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            mcnt = 0; mrr = 0; dut_acc = 0; dut_pops = 0;
        end else begin
            g = -1;
            if (mcnt < DEPTH)
                for (int k = 0; k < NREQ; k++)
                    if (g < 0 && req_valid[(mrr + k) % NREQ]) g = (mrr + k) % NREQ;
            exp_rdy = (g >= 0) ? (NREQ'(1) << g) : NREQ'(0);
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("req_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) gnt_log.push_back(i);
            if ((req_ready & req_valid) != '0) dut_acc++;
            if (res_valid && res_ready) dut_pops++;

            exp_v = (q.size() > 0) && (q[0].due <= cyc);
            chk("res_valid", 32'(res_valid), 32'(exp_v));
            if (exp_v && res_valid) begin
                chk("res_y", res_y, q[0].y);
                chk("res_id", 32'(res_id), 32'(q[0].id));
                chk("res_tag", 32'(res_tag), 32'(q[0].tag));
            end
            if (exp_v && res_ready) begin
                void'(q.pop_front());
                mcnt--;
            end
            if (g >= 0) begin
                e.y = itof(req_n[g]); e.id = g; e.tag = req_t[g];
                // Accepted at the coming edge; visible LAT+1 cycles after sq_x.
                e.due = cyc + LAT + 2;
                q.push_back(e);
                mcnt++;
                mrr = (g + 1) % NREQ;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int n, input int t);
        req_n[i] = n;
        req_t[i] = t;
        req_x[32*i +: 32] = itof(n * n);
        req_tag[TAGW*i +: TAGW] = TAGW'(t);
    endtask

    task automatic drive_rand(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) set_req(i, $urandom_range(0, 4095), $urandom_range(0, 15));
        req_valid = v;
    endtask

    task automatic drain(input int n);
        req_valid = '0;
        res_ready = 1'b1;
        for (int k = 0; k < n && q.size() > 0; k++) step();
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    int acc_cyc, res_cyc, a0;

    initial begin
        rst = 1'b1; req_valid = '0; req_x = '0; req_tag = '0; res_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin req_n[i] = 0; req_t[i] = 0; end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_sq_x", sq_x, 32'd0);
        chk("rst_res_y", res_y, 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_res_tag", 32'(res_tag), 32'd0);

        // Single request: sqrt(4.0) = 2.0.
        step();
        set_req(0, 2, 3);
        chk("single_operand", req_x[31:0], 32'h40800000);
        req_valid = 2'b01;
        acc_cyc = -1;
        for (int k = 0; k < 10 && acc_cyc < 0; k++) begin
            @(negedge clk); #1;
            if (req_ready[0]) acc_cyc = cyc;
        end
        chk("single_accept_seen", 32'(acc_cyc >= 0), 32'd1);
        step();
        req_valid = '0;
        res_cyc = -1;
        for (int k = 0; k < 20 && res_cyc < 0; k++) begin
            @(negedge clk); #1;
            if (res_valid) res_cyc = cyc;
        end
        chk("single_latency", 32'(res_cyc - acc_cyc), 32'(LAT + 2));
        chk("single_y", res_y, 32'h40000000);
        chk("single_id", 32'(res_id), 32'd0);
        chk("single_tag", 32'(res_tag), 32'd3);
        step();

        // Fairness: rr points at 1 after the single grant to 0.
        gnt_log.delete();
        for (int k = 0; k < 8; k++) begin drive_rand(2'b11); step(); end
        req_valid = '0;
        chk("fair_count", 32'(gnt_log.size()), 32'd8);
        for (int k = 0; k < gnt_log.size(); k++) chk("fair_order", 32'(gnt_log[k]), 32'((1 + k) % 2));
        drain(30);

        // Back-pressure, released while writes are still arriving at cnt == DEPTH.
        res_ready = 1'b0;
        a0 = dut_acc;
        for (int k = 0; k < 12; k++) begin drive_rand(2'b11); step(); end
        chk("bp_accepts", 32'(dut_acc - a0), 32'(DEPTH));
        res_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin drive_rand(2'b11); step(); end
        drain(40);

        // Back-pressure until the FIFO itself is full.
        res_ready = 1'b0;
        a0 = dut_acc;
        for (int k = 0; k < 25; k++) begin drive_rand(2'b11); step(); end
        chk("full_accepts", 32'(dut_acc - a0), 32'(DEPTH));
        res_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin drive_rand(2'b11); step(); end
        drain(40);
        chk("bp_no_loss", 32'(dut_pops), 32'(dut_acc));

        // Reset with 3 operations in flight and 2 buffered.
        res_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin drive_rand(2'b01); step(); end
        req_valid = '0;
        repeat (LAT + 3) step();
        for (int k = 0; k < 3; k++) begin drive_rand(2'b01); step(); end
        req_valid = '0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        res_ready = 1'b1;
        for (int k = 0; k < 2 * LAT; k++) begin
            @(negedge clk); #1;
            chk("rst_flight_res_valid", 32'(res_valid), 32'd0);
        end
        step();
        drive_rand(2'b11);
        @(negedge clk); #1;
        chk("rst_rr_zero", 32'(req_ready), 32'd1);
        step();
        drain(30);

        // Randomised traffic against the model.
        for (int k = 0; k < 10000; k++) begin
            drive_rand(NREQ'($urandom_range(0, 3)));
            if (((k / 700) % 2) == 1) res_ready = ($urandom_range(0, 3) == 0);
            else res_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain(200);
        chk("rand_no_loss", 32'(dut_pops), 32'(dut_acc));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
